audio_i2s_rx: RTL
=================

AUDIO_I2S_RX -- requirements
Module: audio_i2s_rx

Interface
REQ-001 Parameter DATA_W, default 16, meaning sample width in bits delivered per channel.
REQ-002 Parameter SYNC_STAGES, default 2, meaning flip-flop depth of input synchronizers (minimum 2).
REQ-003 clk  input  1  system clock; all state changes on rising edge; frequency at least 4x bclk.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 bclk  input  1  codec bit clock, asynchronous to clk.
REQ-006 lrck  input  1  codec word-select, asynchronous; 0 = left slot, 1 = right slot.
REQ-007 sdata  input  1  codec serial data, I2S format, MSB first, changes on bclk falling edge.
REQ-008 sample_l  output  DATA_W  signed left sample of the most recent complete pair.
REQ-009 sample_r  output  DATA_W  signed right sample of the most recent complete pair.
REQ-010 sample_valid  output  1  one-clk pulse: sample_l/sample_r just updated.
REQ-011 frame_err  output  1  one-clk pulse: a slot ended before DATA_W bits were captured.

Function
REQ-012 bclk, lrck, sdata SHALL each pass through SYNC_STAGES flops; one further bclk flop SHALL form a rise detector (sync=1, prev=0).
REQ-013 All capture decisions SHALL occur only in the clk cycle a bclk rise is detected, using synchronized lrck/sdata from that same cycle.
REQ-014 At each detected rise the block SHALL register lrck as lrck_prev; lrck != lrck_prev marks a slot boundary.
REQ-015 The rise at a slot boundary SHALL be the I2S delay bit and carry no data; the next rise captures the MSB.
REQ-016 FSM states: ALIGN, DELAY, SHIFT, HOLD.
REQ-017 ALIGN: ignore data; on first slot boundary with lrck=0 go to DELAY (a right-slot boundary stays in ALIGN).
REQ-018 DELAY: on next rise capture MSB into shift register, bit count=1, go to SHIFT.
REQ-019 SHIFT: each rise shifts sdata in MSB-first, count+1; at count=DATA_W store word to left hold (slot lrck=0) or right hold (lrck=1), go to HOLD.
REQ-020 HOLD: ignore further bits (slots wider than DATA_W, e.g. 24/32-bit); on slot boundary go to DELAY.
REQ-021 Slot boundary during SHIFT (count<DATA_W): discard partial word, invalidate left hold, pulse frame_err next clk, go to DELAY.
REQ-022 Storing the right word while left hold is valid SHALL update sample_l and sample_r together and pulse sample_valid in the following clk; left hold then becomes invalid.
REQ-023 A right word with no valid left hold SHALL be discarded without sample_valid.
REQ-024 Latency: sample_valid SHALL assert exactly 1 clk after the cycle detecting the bclk rise carrying the DATA_W-th right bit.
REQ-025 sample_valid and frame_err SHALL never assert in the same cycle and SHALL be single-cycle pulses.
REQ-026 sample_l/sample_r SHALL hold their values between pulses.
REQ-027 Bit count SHALL saturate at DATA_W; no wrap for any slot length.

Reset
REQ-028 While reset=1: FSM=ALIGN, sample_l=0, sample_r=0, sample_valid=0, frame_err=0, bit count=0, holds invalid, synchronizer and lrck_prev flops=0.
REQ-029 Reset asserted mid-word SHALL discard all partial data; after release the block re-aligns per REQ-017 with no spurious pulses.

Verification
REQ-030 Reset held 3 clk with toggling inputs -> all outputs 0, no pulses.
REQ-031 64fs bclk (32-bit slots), L=16'h1234, R=16'hABCD -> one sample_valid; sample_l=16'h1234, sample_r=16'hABCD (-21555); zero frame_err.
REQ-032 32fs bclk (16-bit slots), 4 pairs L=n, R=-n for n=1..4 -> four pulses, values exact, one pulse per pair.
REQ-033 Release reset while lrck=1 mid right slot, then L=16'h7FFF, R=16'h8000 -> partial slot ignored, first sample_valid shows 16'h7FFF/16'h8000.
REQ-034 lrck toggles after 10 right bits -> one frame_err pulse, no sample_valid, outputs unchanged; next full pair L=16'h0001, R=16'h0002 produces valid.
REQ-035 clk = 4x bclk exactly, random 1000-pair stream -> every pair matches reference model, no missed bits.

Source files
------------

// File: rtl/audio_i2s_rx.sv
// I2S receiver: synchronizes the codec bclk/lrck/sdata into clk and delivers
// left/right sample pairs with a validity pulse, flagging short slots.
module audio_i2s_rx #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     bclk,
  input  logic                     lrck,
  input  logic                     sdata,
  output logic signed [DATA_W-1:0] sample_l,
  output logic signed [DATA_W-1:0] sample_r,
  output logic                     sample_valid,
  output logic                     frame_err
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {ALIGN, DELAY, SHIFT, HOLD} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] bclk_sync, lrck_sync, sdata_sync;
  logic                   bclk_prev, lrck_prev;
  logic                   bclk_s, lrck_s, sdata_s;
  logic                   rise, boundary, last_bit;

  logic [DATA_W-2:0] shift_q, shift_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic [DATA_W-1:0] hold_l_q, hold_l_nxt;
  logic              hold_l_vld_q, hold_l_vld_nxt;
  logic [DATA_W-1:0] word_in;
  logic              store;
  logic [DATA_W-1:0] sample_l_nxt, sample_r_nxt;
  logic              sample_valid_nxt, frame_err_nxt;

  // Input synchronizers plus bclk edge history and per-rise lrck history
  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_sync  <= '0;
      lrck_sync  <= '0;
      sdata_sync <= '0;
      bclk_prev  <= 1'b0;
      lrck_prev  <= 1'b0;
    end else begin
      bclk_sync  <= {bclk_sync[SYNC_STAGES-2:0], bclk};
      lrck_sync  <= {lrck_sync[SYNC_STAGES-2:0], lrck};
      sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], sdata};
      bclk_prev  <= bclk_s;
      if (rise) lrck_prev <= lrck_s;
    end
  end

  assign bclk_s   = bclk_sync[SYNC_STAGES-1];
  assign lrck_s   = lrck_sync[SYNC_STAGES-1];
  assign sdata_s  = sdata_sync[SYNC_STAGES-1];
  assign rise     = bclk_s & ~bclk_prev;
  assign boundary = rise & (lrck_s != lrck_prev);
  assign last_bit = (cnt_q == CNT_W'(DATA_W - 1));
  assign word_in  = {shift_q, sdata_s};

  always_ff @(posedge clk) begin
    if (reset) state <= ALIGN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (rise) begin
      case (state)
        ALIGN: if (boundary && !lrck_s) state_nxt = DELAY;
        DELAY: if (!boundary) state_nxt = SHIFT;
        SHIFT: begin
          if (boundary)      state_nxt = DELAY;
          else if (last_bit) state_nxt = HOLD;
        end
        HOLD:  if (boundary) state_nxt = DELAY;
        default: state_nxt = ALIGN;
      endcase
    end
  end

  // Capture datapath. A slot exactly DATA_W bits wide puts its LSB on the
  // next slot's first bclk, so that rise completes the word as well as
  // serving as the new slot's delay bit.
  always_comb begin
    shift_nxt        = shift_q;
    cnt_nxt          = cnt_q;
    hold_l_nxt       = hold_l_q;
    hold_l_vld_nxt   = hold_l_vld_q;
    sample_l_nxt     = sample_l;
    sample_r_nxt     = sample_r;
    sample_valid_nxt = 1'b0;
    frame_err_nxt    = 1'b0;
    store            = 1'b0;
    if (rise) begin
      case (state)
        DELAY: begin
          if (boundary) begin
            frame_err_nxt  = 1'b1;
            hold_l_vld_nxt = 1'b0;
            cnt_nxt        = '0;
          end else begin
            shift_nxt = word_in[DATA_W-2:0];
            cnt_nxt   = CNT_W'(1);
          end
        end
        SHIFT: begin
          if (boundary && !last_bit) begin
            frame_err_nxt  = 1'b1;
            hold_l_vld_nxt = 1'b0;
            cnt_nxt        = '0;
          end else if (boundary) begin
            store   = 1'b1;
            cnt_nxt = '0;
          end else begin
            shift_nxt = word_in[DATA_W-2:0];
            cnt_nxt   = cnt_q + CNT_W'(1);
            store     = last_bit;
          end
        end
        HOLD: if (boundary) cnt_nxt = '0;
        default: ;
      endcase
    end
    if (store) begin
      if (!lrck_prev) begin
        hold_l_nxt     = word_in;
        hold_l_vld_nxt = 1'b1;
      end else if (hold_l_vld_q) begin
        sample_l_nxt     = hold_l_q;
        sample_r_nxt     = word_in;
        sample_valid_nxt = 1'b1;
        hold_l_vld_nxt   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q      <= '0;
      cnt_q        <= '0;
      hold_l_q     <= '0;
      hold_l_vld_q <= 1'b0;
      sample_l     <= '0;
      sample_r     <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      shift_q      <= shift_nxt;
      cnt_q        <= cnt_nxt;
      hold_l_q     <= hold_l_nxt;
      hold_l_vld_q <= hold_l_vld_nxt;
      sample_l     <= sample_l_nxt;
      sample_r     <= sample_r_nxt;
      sample_valid <= sample_valid_nxt;
      frame_err    <= frame_err_nxt;
    end
  end

endmodule
